// File: rtl/prio_event_encoder.sv
// Registered priority encoder for N active-low event inputs with sticky pending bits,
// valid/ready grant handshake, fixed or round-robin selection and 74148-style cascade pins.
module prio_event_encoder #(
   parameter int N  = 8,
   parameter int W  = 3,
   parameter bit RR = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_n,
   input  logic         ei_n,
   output logic [W-1:0] code,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         gs_n,
   output logic         eo_n,
   output logic         overflow
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t         state_reg;
   logic [N-1:0]   req_reg;
   logic [N-1:0]   pend_reg;
   logic [N-1:0]   pend_next;
   logic [W-1:0]   code_reg;
   logic [W-1:0]   ptr_reg;
   logic           out_valid_reg;
   logic           overflow_reg;

   logic [N-1:0]   fall;
   logic [N-1:0]   clr;
   logic           handshake;
   logic [W-1:0]   sel_idx;
   logic           sel_found;

   assign handshake = out_valid_reg & out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         assign fall[gi] = req_reg[gi] & ~req_n[gi] & ~ei_n;
         assign clr[gi]  = handshake & (code_reg == W'(gi));
      end
   endgenerate

   // A new event on the same cycle as its clear keeps the bit pending.
   assign pend_next = (pend_reg & ~clr) | fall;

   always_comb begin
      int idx;
      idx       = 0;
      sel_idx   = '0;
      sel_found = 1'b0;
      if (RR) begin
         // Scan downward from ptr_reg inclusive, wrapping from 0 to N-1.
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) - k;
            if (idx < 0) begin
               idx = idx + N;
            end
            if (!sel_found && pend_reg[idx]) begin
               sel_found = 1'b1;
               sel_idx   = W'(idx);
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (pend_reg[i]) begin
               sel_found = 1'b1;
               sel_idx   = W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         req_reg       <= '1;
         pend_reg      <= '0;
         code_reg      <= '0;
         ptr_reg       <= W'(N - 1);
         out_valid_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         req_reg      <= req_n;
         pend_reg     <= pend_next;
         overflow_reg <= |(fall & pend_reg & ~clr);
         case (state_reg)
            IDLE: begin
               if (!ei_n && sel_found) begin
                  code_reg      <= sel_idx;
                  out_valid_reg <= 1'b1;
                  state_reg     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
                  ptr_reg       <= (code_reg == '0) ? W'(N - 1) : code_reg - W'(1);
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign code      = code_reg;
   assign out_valid = out_valid_reg;
   assign overflow  = overflow_reg;
   assign gs_n      = ~out_valid_reg;
   // Downstream device may run only while this one is enabled and fully idle.
   assign eo_n      = ~(~ei_n & ~(|pend_reg) & ~out_valid_reg);

endmodule
